// File: rtl/aes_round_ctrl_if.sv
// Handshake and control bundle between the AES round controller and its neighbours.
// The master side drives the request inputs; the slave side (controller) drives status/strobes.
interface aes_round_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic        abort;
    logic        load_state;
    logic        state_en;
    logic        skip_mix;
    logic [3:0]  round_idx;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] blk_count;

    modport master (
        output in_valid, abort, out_ready,
        input  in_ready, load_state, state_en, skip_mix, round_idx, busy, out_valid, blk_count
    );

    modport slave (
        input  in_valid, abort, out_ready,
        output in_ready, load_state, state_en, skip_mix, round_idx, busy, out_valid, blk_count
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// Sequencer for the iterative AES-128 round datapath: initial key add, then NUM_ROUNDS rounds.
// Optional completed-block counter enabled by defining AES_CTRL_BLK_COUNT_EN.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for a plaintext block, in_ready high
// S_LOAD  | one cycle: state register <= plaintext ^ round-0 key
// S_ROUND | stepping the datapath, one state_en every ROUND_LAT cycles
// S_DONE  | ciphertext held, out_valid high until out_ready
module aes_round_ctrl #(
    parameter int ROUND_LAT  = 3,
    parameter int NUM_ROUNDS = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    aes_round_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [3:0] LAT_LAST  = 4'(ROUND_LAT - 1);
    localparam logic [3:0] LAST_RND  = 4'(NUM_ROUNDS);

    state_e     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [3:0] lat_q, lat_d;

    logic in_ready_c, load_c, state_en_c, skip_c, busy_c, out_valid_c;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            round_q <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            lat_q   <= lat_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        lat_d       = lat_q;
        in_ready_c  = 1'b0;
        load_c      = 1'b0;
        state_en_c  = 1'b0;
        skip_c      = 1'b0;
        busy_c      = 1'b0;
        out_valid_c = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                in_ready_c = 1'b1;
                round_d    = '0;
                lat_d      = '0;
                if (bus.in_valid) state_d = S_LOAD;
            end
            S_LOAD: begin
                load_c  = 1'b1;
                busy_c  = 1'b1;
                state_d = S_ROUND;
                round_d = 4'd1;
                lat_d   = '0;
            end
            S_ROUND: begin
                busy_c = 1'b1;
                skip_c = (round_q == LAST_RND);
                if (lat_q == LAT_LAST) begin
                    state_en_c = 1'b1;
                    lat_d      = '0;
                    if (round_q == LAST_RND) state_d = S_DONE;
                    else                     round_d = round_q + 4'd1;
                end else begin
                    lat_d = lat_q + 4'd1;
                end
            end
            S_DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                    round_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // abort wins over everything and suppresses this cycle's strobes
        if (bus.abort) begin
            state_d     = S_IDLE;
            round_d     = '0;
            lat_d       = '0;
            load_c      = 1'b0;
            state_en_c  = 1'b0;
            out_valid_c = 1'b0;
        end
    end

    assign bus.in_ready   = in_ready_c  & ~rst_i;
    assign bus.load_state = load_c      & ~rst_i;
    assign bus.state_en   = state_en_c  & ~rst_i;
    assign bus.skip_mix   = skip_c      & ~rst_i;
    assign bus.busy       = busy_c      & ~rst_i;
    assign bus.out_valid  = out_valid_c & ~rst_i;
    assign bus.round_idx  = rst_i ? 4'd0 : round_q;

`ifdef AES_CTRL_BLK_COUNT_EN
    logic [31:0] blk_cnt_q, blk_cnt_d;

    always_comb begin
        blk_cnt_d = blk_cnt_q;
        if (state_q == S_DONE && bus.out_ready && !bus.abort) blk_cnt_d = blk_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) blk_cnt_q <= '0;
        else       blk_cnt_q <= blk_cnt_d;
    end

    assign bus.blk_count = rst_i ? 32'd0 : blk_cnt_q;
`else
    assign bus.blk_count = 32'd0;
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard-based bench for aes_round_ctrl: default ROUND_LAT=3 instance plus a ROUND_LAT=1 instance.
module tb_aes_round_ctrl;

`ifdef AES_CTRL_BLK_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_round_ctrl_if bus ();
    aes_round_ctrl_if bus1 ();

    aes_round_ctrl dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    aes_round_ctrl #(.ROUND_LAT(1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));

    typedef struct {
        int          lat;
        int          se;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_cnt = 32'd0;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;  bus.abort = 1'b0;  bus.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.abort = 1'b0; bus1.out_ready = 1'b0;
        tick();
        tick();
        total++;
        if ({bus.in_ready, bus.busy, bus.out_valid, bus.load_state, bus.state_en, bus.skip_mix} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outs actual=%b required=000000",
                     {bus.in_ready, bus.busy, bus.out_valid, bus.load_state, bus.state_en, bus.skip_mix});
        end
        rst = 1'b0;
        #1;
        total++;
        if (bus.in_ready !== 1'b1 || bus.round_idx !== 4'd0 || bus.blk_count !== 32'd0) begin
            bad++;
            $display("FAIL reset_idle actual=in_ready:%b round:%0d cnt:%0d required=1/0/0",
                     bus.in_ready, bus.round_idx, bus.blk_count);
        end
    endtask

    task automatic run_block(input int hold);
        exp_t e;
        int   c, se_n, pat_err;
        logic exp_se;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL blk_in_ready actual=%b required=1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        e.lat = 31;
        e.se  = 10;
        e.cnt = CNT_EN ? exp_cnt + 32'd1 : 32'd0;
        sbq.push_back(e);
        total++;
        if (bus.load_state !== 1'b1) begin
            bad++;
            $display("FAIL blk_load actual=%b required=1", bus.load_state);
        end
        c = 1; se_n = 0; pat_err = 0;
        while (bus.out_valid !== 1'b1 && c < 80) begin
            exp_se = (c >= 4 && c <= 31 && (c - 1) % 3 == 0);
            if (bus.state_en !== exp_se) pat_err++;
            if (bus.skip_mix !== (c >= 29 && c <= 31)) pat_err++;
            if (c > 1 && bus.load_state !== 1'b0) pat_err++;
            if (bus.state_en === 1'b1) se_n++;
            tick();
            c++;
        end
        for (int i = 0; i < hold; i++) begin
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.round_idx !== 4'd10) pat_err++;
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        e = sbq.pop_front();
        total++;
        if (c - 1 !== e.lat) begin
            bad++;
            $display("FAIL blk_latency actual=%0d required=%0d", c - 1, e.lat);
        end
        total++;
        if (se_n !== e.se) begin
            bad++;
            $display("FAIL blk_state_en_cnt actual=%0d required=%0d", se_n, e.se);
        end
        total++;
        if (pat_err !== 0) begin
            bad++;
            $display("FAIL blk_strobe_pattern actual=%0d errors required=0 (hold=%0d)", pat_err, hold);
        end
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL blk_back_idle actual=in_ready:%b out_valid:%b required=1/0", bus.in_ready, bus.out_valid);
        end
        total++;
        if (bus.blk_count !== e.cnt) begin
            bad++;
            $display("FAIL blk_count actual=%0h required=%0h", bus.blk_count, e.cnt);
        end
        exp_cnt = e.cnt;
        if (hold > 0) begin
            tick();
            total++;
            if (bus.out_valid !== 1'b0 || bus.blk_count !== e.cnt) begin
                bad++;
                $display("FAIL bp_single_hs actual=out_valid:%b cnt:%0h required=0/%0h",
                         bus.out_valid, bus.blk_count, e.cnt);
            end
        end
    endtask

    task automatic test_abort();
        exp_t e;
        int   g, stray;
        bus.in_valid = 1'b1;
        bus.abort    = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.abort    = 1'b0;
        total++;
        if (bus.load_state !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_idle_prio actual=load:%b in_ready:%b required=0/1", bus.load_state, bus.in_ready);
        end
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        e.lat = 31; e.se = 10; e.cnt = exp_cnt + 32'd1;
        sbq.push_back(e);
        g = 0;
        while (bus.round_idx !== 4'd5 && g < 40) begin
            tick();
            g++;
        end
        total++;
        if (bus.round_idx !== 4'd5) begin
            bad++;
            $display("FAIL abort_reach_r5 actual=%0d required=5", bus.round_idx);
        end
        tick();
        bus.abort = 1'b1;
        #1;
        total++;
        if (bus.state_en !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_cycle actual=se:%b ov:%b busy:%b required=0/0/1", bus.state_en, bus.out_valid, bus.busy);
        end
        tick();
        bus.abort = 1'b0;
        void'(sbq.pop_back());
        total++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.round_idx !== 4'd0) begin
            bad++;
            $display("FAIL abort_next_idle actual=in_ready:%b busy:%b round:%0d required=1/0/0",
                     bus.in_ready, bus.busy, bus.round_idx);
        end
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.state_en !== 1'b0 || bus.out_valid !== 1'b0 || bus.load_state !== 1'b0) stray++;
            tick();
        end
        total++;
        if (stray !== 0 || bus.blk_count !== exp_cnt) begin
            bad++;
            $display("FAIL abort_no_output actual=stray:%0d cnt:%0h required=0/%0h", stray, bus.blk_count, exp_cnt);
        end
        run_block(0);
    endtask

    task automatic test_rst_mid();
        int g;
        for (int ph = 0; ph < 2; ph++) begin
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b0;
            tick();
            bus.in_valid = 1'b0;
            g = 0;
            while (g < 80 && ((ph == 0) ? (bus.round_idx !== 4'd3) : (bus.out_valid !== 1'b1))) begin
                tick();
                g++;
            end
            total++;
            if (((ph == 0) ? bus.busy : bus.out_valid) !== 1'b1) begin
                bad++;
                $display("FAIL rst_setup ph=%0d actual=0 required=1", ph);
            end
            rst = 1'b1;
            #1;
            total++;
            if ({bus.in_ready, bus.busy, bus.out_valid, bus.load_state, bus.state_en, bus.skip_mix} !== 6'b0 ||
                bus.round_idx !== 4'd0 || bus.blk_count !== 32'd0) begin
                bad++;
                $display("FAIL rst_outs_zero ph=%0d actual=%b round:%0d cnt:%0h required=000000/0/0", ph,
                         {bus.in_ready, bus.busy, bus.out_valid, bus.load_state, bus.state_en, bus.skip_mix},
                         bus.round_idx, bus.blk_count);
            end
            tick();
            rst = 1'b0;
            #1;
            total++;
            if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 ||
                bus.round_idx !== 4'd0 || bus.blk_count !== 32'd0) begin
                bad++;
                $display("FAIL rst_after_idle ph=%0d actual=in_ready:%b busy:%b ov:%b round:%0d cnt:%0h", ph,
                         bus.in_ready, bus.busy, bus.out_valid, bus.round_idx, bus.blk_count);
            end
            @(negedge clk);
        end
        exp_cnt = 32'd0;
        sbq.delete();
    endtask

    task automatic test_round_lat1();
        exp_t e;
        int   c, se_n, pat_err;
        bus1.in_valid  = 1'b1;
        bus1.out_ready = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        e.lat = 11; e.se = 10; e.cnt = 32'd0;
        sbq.push_back(e);
        c = 1; se_n = 0; pat_err = 0;
        while (bus1.out_valid !== 1'b1 && c < 40) begin
            if (bus1.state_en !== (c >= 2 && c <= 11)) pat_err++;
            if (bus1.state_en === 1'b1) se_n++;
            tick();
            c++;
        end
        e = sbq.pop_front();
        total++;
        if (c - 1 !== e.lat) begin
            bad++;
            $display("FAIL lat1_latency actual=%0d required=%0d", c - 1, e.lat);
        end
        total++;
        if (se_n !== e.se || pat_err !== 0) begin
            bad++;
            $display("FAIL lat1_state_en actual=pulses:%0d errs:%0d required=%0d/0", se_n, pat_err, e.se);
        end
        tick();
        total++;
        if (bus1.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL lat1_back_idle actual=%b required=1", bus1.in_ready);
        end
    endtask

    task automatic test_blk_count();
        for (int i = 0; i < 3; i++) run_block(0);
        total++;
        if (bus.blk_count !== (CNT_EN ? 32'd3 : 32'd0)) begin
            bad++;
            $display("FAIL cnt_three actual=%0d required=%0d", bus.blk_count, CNT_EN ? 3 : 0);
        end
`ifdef AES_CTRL_BLK_COUNT_EN
        force dut.blk_cnt_q = 32'hFFFF_FFFF;
        tick();
        release dut.blk_cnt_q;
        exp_cnt = 32'hFFFF_FFFF;
        run_block(0);
        total++;
        if (bus.blk_count !== 32'd0) begin
            bad++;
            $display("FAIL cnt_wrap actual=%0h required=0", bus.blk_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        run_block(0);
        run_block(20);
        test_abort();
        test_rst_mid();
        test_round_lat1();
        test_blk_count();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
